// File: rtl/clksel_ctrl.sv
// Clock-selection requester for the CPU clock switch: picks host clock or HS
// divided clock, stalls the CPU during a switch and falls back on timeout.
module clksel_ctrl #(
   parameter int unsigned DWELL_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic hsclk_in,
   input  logic rst_b,
   input  logic turbo_en,
   input  logic host_access,
   input  logic err_clr,
   input  logic hsclk_selected,
   input  logic lsclk_selected,
   output logic hsclk_sel,
   output logic cpu_rdy,
   output logic switch_busy,
   output logic timeout_err
);

   typedef enum logic [1:0] {
      LS_RUN,
      TO_HS,
      HS_RUN,
      TO_LS
   } state_t;

   localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] dwell, dwell_nx;
   logic [CNT_W-1:0] tmo_cnt, tmo_nx;
   logic             err_nx, tmo_hit;
   logic             hs_meta, hs_s, ls_meta, ls_s;

   // Feedback synchronizers; idle value matches the switch sitting on LS.
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         hs_meta <= 1'b0;
         hs_s    <= 1'b0;
         ls_meta <= 1'b1;
         ls_s    <= 1'b1;
      end else begin
         hs_meta <= hsclk_selected;
         hs_s    <= hs_meta;
         ls_meta <= lsclk_selected;
         ls_s    <= ls_meta;
      end
   end

   always_comb begin
      state_nx = state;
      dwell_nx = dwell;
      tmo_nx   = tmo_cnt;
      err_nx   = timeout_err;
      tmo_hit  = (tmo_cnt == TMO_LIM);
      if (err_clr)
         err_nx = 1'b0;
      case (state)
         LS_RUN: begin
            if (host_access)
               dwell_nx = DWELL_LD;
            else if (dwell != '0)
               dwell_nx = dwell - ONE;
            if (turbo_en && !host_access && (dwell == '0) && !timeout_err) begin
               state_nx = TO_HS;
               tmo_nx   = '0;
            end
         end
         TO_HS: begin
            if (hs_s && !ls_s)
               state_nx = HS_RUN;
            else if (!turbo_en || host_access) begin
               state_nx = TO_LS;
               tmo_nx   = '0;
            end else if (tmo_hit) begin
               state_nx = LS_RUN;
               dwell_nx = DWELL_LD;
               err_nx   = 1'b1;
            end else if (tmo_cnt != '1)
               tmo_nx = tmo_cnt + ONE;
         end
         HS_RUN: begin
            if (host_access || !turbo_en) begin
               state_nx = TO_LS;
               tmo_nx   = '0;
            end
         end
         TO_LS: begin
            if (ls_s && !hs_s) begin
               state_nx = LS_RUN;
               dwell_nx = DWELL_LD;
            end else if (tmo_hit) begin
               state_nx = LS_RUN;
               dwell_nx = DWELL_LD;
               err_nx   = 1'b1;
            end else if (tmo_cnt != '1)
               tmo_nx = tmo_cnt + ONE;
         end
         default: state_nx = LS_RUN;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge.
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         state       <= LS_RUN;
         dwell       <= DWELL_LD;
         tmo_cnt     <= '0;
         hsclk_sel   <= 1'b0;
         cpu_rdy     <= 1'b1;
         switch_busy <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         dwell       <= dwell_nx;
         tmo_cnt     <= tmo_nx;
         hsclk_sel   <= (state_nx == TO_HS) || (state_nx == HS_RUN);
         cpu_rdy     <= (state_nx == LS_RUN) || (state_nx == HS_RUN);
         switch_busy <= (state_nx == TO_HS) || (state_nx == TO_LS);
         timeout_err <= err_nx;
      end
   end

endmodule
